// File: rtl/read_tick_sequencer_pkg.sv
// Shared definitions for the read-clock paced memory read sequencer.
//   - FSM state encodings (2-bit) used by read_tick_sequencer.
//   - Upper limit on memory latency and the matching wait-counter width.
package read_tick_sequencer_pkg;

    // Longest memory latency the block supports. One READ_CLK period is 64 system
    // cycles, so this limit keeps a read finished before the next tick.
    localparam int unsigned MaxMemLatency = 32;

    // Wide enough to hold MaxMemLatency - 1.
    localparam int unsigned CntWidth = $clog2(MaxMemLatency);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

endpackage

// File: rtl/read_clk_edge_detect.sv
// Rising-edge detector for the divided read clock, which arrives as a plain data
// signal in the system clock domain.
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   read_clk_i divided read clock, sampled as data
//   tick_o     one-cycle pulse per rising edge of read_clk_i
module read_clk_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic read_clk_i,
    output logic tick_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // s1/s2 synchronise, s3 holds the previous value. All reset to 1 so a read
    // clock that is already high when reset drops does not produce a tick; it
    // has to be seen low first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= read_clk_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tick_o = s2_q & ~s3_q;

endmodule

// File: rtl/read_tick_sequencer.sv
// Turns the divided read clock into paced single-word memory reads.
// A request is latched in IDLE, waits for the next read-clock tick, issues a
// one-cycle read strobe, waits MEM_LATENCY cycles, then returns the word with a
// one-cycle valid pulse.
//   IN_50Mhz    system clock
//   RESET       asynchronous active-high reset
//   READ_CLK    divided read clock (treated as data)
//   REQ         read request, only accepted in IDLE
//   REQ_ADDR    request address, latched on acceptance
//   OVERRUN_CLR clears OVERRUN (loses to a simultaneous set)
//   MEM_DATA    memory read data
//   MEM_ADDR    latched address
//   MEM_RD      one-cycle read strobe
//   DATA_OUT    last captured word
//   DATA_VALID  one-cycle pulse with a new DATA_OUT
//   BUSY        high outside IDLE
//   TICK        one-cycle pulse per READ_CLK rising edge
//   OVERRUN     sticky flag: request arrived while busy and was dropped
module read_tick_sequencer
    import read_tick_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                  IN_50Mhz,
    input  logic                  RESET,
    input  logic                  READ_CLK,
    input  logic                  REQ,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic                  OVERRUN_CLR,
    input  logic [DATA_WIDTH-1:0] MEM_DATA,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_RD,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  DATA_VALID,
    output logic                  BUSY,
    output logic                  TICK,
    output logic                  OVERRUN
);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  tick;
    logic                  busy;

    read_clk_edge_detect u_edge (
        .clk_i      (IN_50Mhz),
        .rst_i      (RESET),
        .read_clk_i (READ_CLK),
        .tick_o     (tick)
    );

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ) begin
                    addr_d  = REQ_ADDR;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // Only ticks sampled after acceptance count, since IDLE ignores them.
                if (tick) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Strobe is sampled by memory at the edge leaving ISSUE, so the
                // counter starts one short of the full latency.
                cnt_d   = CntWidth'(MEM_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = MEM_DATA;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Set wins over clear so a back-to-back overrun is never lost.
    always_comb begin
        overrun_d = overrun_q;
        if (REQ && busy) begin
            overrun_d = 1'b1;
        end else if (OVERRUN_CLR) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge IN_50Mhz or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign MEM_ADDR   = addr_q;
    assign MEM_RD     = (state_q == ISSUE);
    assign DATA_OUT   = data_q;
    assign DATA_VALID = valid_q;
    assign BUSY       = busy;
    assign TICK       = tick;
    assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_read_tick_sequencer.sv
// Directed bench for read_tick_sequencer with a latency-2 memory model.
module tb_read_tick_sequencer;

    logic        IN_50Mhz;
    logic        RESET;
    logic        READ_CLK;
    logic        REQ;
    logic [7:0]  REQ_ADDR;
    logic        OVERRUN_CLR;
    logic [15:0] MEM_DATA;
    logic [7:0]  MEM_ADDR;
    logic        MEM_RD;
    logic [15:0] DATA_OUT;
    logic        DATA_VALID;
    logic        BUSY;
    logic        TICK;
    logic        OVERRUN;

    read_tick_sequencer #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (16),
        .MEM_LATENCY (2)
    ) dut (
        .IN_50Mhz    (IN_50Mhz),
        .RESET       (RESET),
        .READ_CLK    (READ_CLK),
        .REQ         (REQ),
        .REQ_ADDR    (REQ_ADDR),
        .OVERRUN_CLR (OVERRUN_CLR),
        .MEM_DATA    (MEM_DATA),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_RD      (MEM_RD),
        .DATA_OUT    (DATA_OUT),
        .DATA_VALID  (DATA_VALID),
        .BUSY        (BUSY),
        .TICK        (TICK),
        .OVERRUN     (OVERRUN)
    );

    initial IN_50Mhz = 1'b0;
    always #10 IN_50Mhz = ~IN_50Mhz;

    // Memory model: strobe sampled at edge N, data presented for the edge N+2.
    logic       rd_d1 = 1'b0;
    logic       rd_d2 = 1'b0;
    logic [7:0] a1 = 8'h00;
    logic [7:0] a2 = 8'h00;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        if (a == 8'h3C) return 16'hBEEF;
        return {a, ~a};
    endfunction

    always @(posedge IN_50Mhz) begin
        rd_d1 <= MEM_RD;
        rd_d2 <= rd_d1;
        a1    <= MEM_ADDR;
        a2    <= a1;
    end

    assign MEM_DATA = rd_d2 ? mem_word(a2) : 16'hDEAD;

    int checks   = 0;
    int failures = 0;

    // Bench-side bookkeeping (cycle numbers are sample points #1 after an edge).
    int         cyc        = 0;
    logic [5:0] rc_ph      = 6'd0;
    int         rise_cyc   = -1;
    int         first_rise = -1;
    int         first_tick = -1;
    int         last_tick  = -1;
    int         tick_cnt   = 0;
    int         wide_cnt   = 0;
    int         min_gap    = 1000;
    int         max_gap    = 0;
    logic       prev_tick  = 1'b0;
    int         rd_cnt     = 0;
    int         last_rd    = -1;
    logic [7:0] rd_addr    = 8'h00;
    int         dv_cnt     = 0;
    int         last_dv    = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One system cycle with the free-running read clock driven from rc_ph.
    task automatic step();
        READ_CLK = rc_ph[5];
        @(posedge IN_50Mhz);
        #1;
        cyc++;
        if (rc_ph == 6'd32) begin
            rise_cyc = cyc;
            if (first_rise < 0) first_rise = cyc;
        end
        rc_ph = rc_ph + 6'd1;
        if (TICK) begin
            if (prev_tick) wide_cnt++;
            if (last_tick >= 0) begin
                if (cyc - last_tick < min_gap) min_gap = cyc - last_tick;
                if (cyc - last_tick > max_gap) max_gap = cyc - last_tick;
            end
            if (first_tick < 0) first_tick = cyc;
            last_tick = cyc;
            tick_cnt++;
        end
        prev_tick = TICK;
        if (MEM_RD) begin
            rd_cnt++;
            last_rd = cyc;
            rd_addr = MEM_ADDR;
        end
        if (DATA_VALID) begin
            dv_cnt++;
            last_dv = cyc;
        end
    endtask

    task automatic run_until_dv(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 120 && !seen; i++) begin
            step();
            seen = DATA_VALID;
        end
    endtask

    task automatic run_until_rd(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 120 && !seen; i++) begin
            step();
            seen = MEM_RD;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_addr"},   32'(MEM_ADDR),   32'h0);
        chk({tag, "_mem_rd"},     32'(MEM_RD),     32'h0);
        chk({tag, "_data_out"},   32'(DATA_OUT),   32'h0);
        chk({tag, "_data_valid"}, 32'(DATA_VALID), 32'h0);
        chk({tag, "_busy"},       32'(BUSY),       32'h0);
        chk({tag, "_overrun"},    32'(OVERRUN),    32'h0);
    endtask

    initial begin
        bit seen;
        int hold_ticks;
        int rd0;
        int dv0;
        int rise0;

        RESET       = 1'b1;
        READ_CLK    = 1'b1;
        REQ         = 1'b0;
        REQ_ADDR    = 8'h00;
        OVERRUN_CLR = 1'b0;

        // Reset with READ_CLK held high.
        repeat (3) @(posedge IN_50Mhz);
        #1;
        chk_idle_outputs("in_reset");
        chk("in_reset_tick", 32'(TICK), 32'h0);
        RESET = 1'b0;
        hold_ticks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge IN_50Mhz);
            #1;
            if (TICK) hold_ticks++;
        end
        chk("hold_high_no_tick", 32'(hold_ticks), 32'h0);
        chk_idle_outputs("after_reset");

        // 32 low cycles, then three free-running periods.
        rc_ph = 6'd0;
        for (int i = 0; i < 32; i++) step();
        chk("low_no_tick", 32'(tick_cnt), 32'h0);
        for (int i = 0; i < 192; i++) step();
        chk("tick_count",      32'(tick_cnt),   32'd3);
        chk("first_tick_cyc",  32'(first_tick), 32'(first_rise + 1));
        chk("tick_min_gap",    32'(min_gap),    32'd64);
        chk("tick_max_gap",    32'(max_gap),    32'd64);
        chk("tick_width",      32'(wide_cnt),   32'd0);

        // Move into the low half of the period before requesting.
        for (int i = 0; i < 40; i++) step();

        // Request 0x3C, then overrun handling while ARMED.
        rd0 = rd_cnt;
        dv0 = dv_cnt;
        REQ = 1'b1; REQ_ADDR = 8'h3C;
        step();
        chk("accept_addr", 32'(MEM_ADDR), 32'h3C);
        chk("accept_busy", 32'(BUSY), 32'h1);
        REQ_ADDR = 8'h55;
        step();
        chk("overrun_set",       32'(OVERRUN),  32'h1);
        chk("overrun_addr_held", 32'(MEM_ADDR), 32'h3C);
        REQ_ADDR = 8'h66; OVERRUN_CLR = 1'b1;
        step();
        chk("overrun_set_beats_clr", 32'(OVERRUN), 32'h1);
        REQ = 1'b0;
        step();
        chk("overrun_cleared", 32'(OVERRUN), 32'h0);
        OVERRUN_CLR = 1'b0;

        run_until_dv(seen);
        chk("t1_dv_seen",   32'(seen),     32'h1);
        chk("t1_rd_count",  32'(rd_cnt),   32'(rd0 + 1));
        chk("t1_rd_cyc",    32'(last_rd),  32'(rise_cyc + 2));
        chk("t1_rd_addr",   32'(rd_addr),  32'h3C);
        chk("t1_dv_cyc",    32'(last_dv),  32'(rise_cyc + 5));
        chk("t1_data",      32'(DATA_OUT), 32'hBEEF);
        chk("t1_busy_low",  32'(BUSY),     32'h0);

        // Request 0x10 in the DATA_VALID cycle.
        rise0 = rise_cyc;
        REQ = 1'b1; REQ_ADDR = 8'h10;
        step();
        REQ = 1'b0;
        chk("t1_dv_once",     32'(dv_cnt),     32'(dv0 + 1));
        chk("t1_dv_pulse",    32'(DATA_VALID), 32'h0);
        chk("t2_accept_addr", 32'(MEM_ADDR),   32'h10);
        chk("t2_busy",        32'(BUSY),       32'h1);
        chk("t2_no_overrun",  32'(OVERRUN),    32'h0);
        run_until_dv(seen);
        chk("t2_dv_seen",    32'(seen),                32'h1);
        chk("t2_new_tick",   32'(rise_cyc > rise0),    32'h1);
        chk("t2_rd_cyc",     32'(last_rd),             32'(rise_cyc + 2));
        chk("t2_rd_addr",    32'(rd_addr),             32'h10);
        chk("t2_dv_cyc",     32'(last_dv),             32'(rise_cyc + 5));
        chk("t2_data",       32'(DATA_OUT),            32'h10EF);
        chk("t2_no_overrun_end", 32'(OVERRUN),         32'h0);

        // Reset asserted while waiting on memory.
        for (int i = 0; i < 10; i++) step();
        REQ = 1'b1; REQ_ADDR = 8'h77;
        step();
        REQ = 1'b0;
        run_until_rd(seen);
        chk("t3_rd_seen", 32'(seen), 32'h1);
        step();
        chk("t3_waiting", 32'(BUSY), 32'h1);
        dv0 = dv_cnt;
        RESET = 1'b1;
        #1;
        chk_idle_outputs("mid_reset");
        for (int i = 0; i < 4; i++) step();
        RESET = 1'b0;
        chk("t3_no_dv", 32'(dv_cnt), 32'(dv0));

        // Normal request after the abandoned one.
        rd0 = rd_cnt;
        REQ = 1'b1; REQ_ADDR = 8'hA5;
        step();
        REQ = 1'b0;
        run_until_dv(seen);
        chk("t4_dv_seen",  32'(seen),     32'h1);
        chk("t4_rd_count", 32'(rd_cnt),   32'(rd0 + 1));
        chk("t4_rd_cyc",   32'(last_rd),  32'(rise_cyc + 2));
        chk("t4_dv_cyc",   32'(last_dv),  32'(rise_cyc + 5));
        chk("t4_data",     32'(DATA_OUT), 32'hA55A);
        chk("t4_addr",     32'(MEM_ADDR), 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
